// File: rtl/sub32_serial.sv
// sub32_serial: 32-bit subtractor, a - b - borrow_in, one 8-bit slice per clock.
// Valid/ready on both sides; borrow_out, true sign and overflow registered.
module sub32_serial #(
    parameter int SLICE_W = 8,
    parameter int NSLICE  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICE_W*NSLICE-1:0] a,
    input  logic [SLICE_W*NSLICE-1:0] b,
    input  logic                      borrow_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICE_W*NSLICE-1:0] diff,
    output logic                      borrow_out,
    output logic                      sign,
    output logic                      overflow
);

    localparam int W   = SLICE_W * NSLICE;
    localparam int K_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       diff_q;
    logic [K_W-1:0]     k_q;
    logic               carry_q;
    logic               borrow_q;
    logic               sign_q;
    logic               ovf_q;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W:0]   sum;
    logic               ovf_next;
    logic               last_slice;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign sign       = sign_q;
    assign overflow   = ovf_q;

    assign last_slice = (k_q == K_LAST);

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (k_q == K_W'(i)) begin
                a_sl = a_q[i*SLICE_W +: SLICE_W];
                b_sl = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    // Subtract as a + ~b + carry, carry starting at ~borrow_in.
    assign sum = {1'b0, a_sl}
               + {1'b0, ~b_sl}
               + {{SLICE_W{1'b0}}, carry_q};

    // sum[SLICE_W-1] is the final diff MSB when on the last slice.
    assign ovf_next = (a_q[W-1] != b_q[W-1])
                   && (sum[SLICE_W-1] != a_q[W-1]);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = CALC;
            CALC: if (last_slice) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            k_q      <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ~borrow_in;
                        k_q     <= '0;
                    end
                end
                CALC: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (k_q == K_W'(i)) begin
                            diff_q[i*SLICE_W +: SLICE_W] <= sum[SLICE_W-1:0];
                        end
                    end
                    carry_q <= sum[SLICE_W];
                    k_q     <= k_q + 1'b1;
                    if (last_slice) begin
                        borrow_q <= ~sum[SLICE_W];
                        ovf_q    <= ovf_next;
                        sign_q   <= sum[SLICE_W-1] ^ ovf_next;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub32_serial.sv
// tb_sub32_serial: directed vector table plus handshake/backpressure/reset
// sequences for the serial 32-bit subtractor.
module tb_sub32_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow_out;
    logic        sign;
    logic        overflow;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        bo;
        logic        sgn;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    sub32_serial dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .sign       (sign),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int c;
        c = 0;
        while (!in_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Presents operands, then scrambles the ports to prove they were captured.
    task automatic start_op(input logic [31:0] va, input logic [31:0] vb,
                            input logic vbin);
        wait_ready();
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        borrow_in = vbin;
        @(negedge clk);
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        borrow_in = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(input string name);
        int c;
        c = 0;
        while (!out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check({name, "_latency"}, c, 4);
    endtask

    task automatic check_result(input string name, input vec_t v);
        check({name, "_diff"}, diff, v.diff);
        check({name, "_borrow"}, 32'(borrow_out), 32'(v.bo));
        check({name, "_sign"}, 32'(sign), 32'(v.sgn));
        check({name, "_ovf"}, 32'(overflow), 32'(v.ovf));
        check({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic accept(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({name, "_ir_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;

        vecs[0] = '{32'd5,        32'd3,        1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd0,        32'd1,        1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h100,      32'd1,        1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'd10,       32'd3,        1'b1, 32'h0000_0006, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'd1,       1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'd0,        32'd0,        1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{32'h1234_5678, 32'h00FF_00FF, 1'b0, 32'h1135_5579, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", diff, 32'd0);
        check("rst_flags", {29'd0, borrow_out, sign, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_result(nm);
            check_result(nm, vecs[i]);
            accept(nm);
        end

        // Backpressure: hold result, poke in_valid with other operands.
        start_op(vecs[4].a, vecs[4].b, vecs[4].bin);
        wait_result("bp");
        for (int i = 0; i < 10; i++) begin
            in_valid  = i[0];
            a         = 32'd100 + i;
            b         = 32'd7;
            borrow_in = 1'b0;
            @(negedge clk);
            check_result($sformatf("bp_hold%0d", i), vecs[4]);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        accept("bp");
        repeat (6) @(negedge clk);
        check("bp_not_queued", 32'(out_valid), 32'd0);

        // Reset in mid-calculation once k has reached 2.
        start_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_diff", diff, 32'd0);
        check("mid_rst_flags", {29'd0, borrow_out, sign, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("mid_rst_no_result", seen, 0);
        end

        start_op(vecs[8].a, vecs[8].b, vecs[8].bin);
        wait_result("post_rst");
        check_result("post_rst", vecs[8]);
        accept("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
